// File: rtl/mcp4725_pkg.sv
// Shared constants for the MCP4725 DAC wave sequencer: IIC core commands,
// waveform modes, fast-write framing bits and the sequencer FSM states.
package mcp4725_pkg;

  localparam logic [1:0] CALL_IDLE  = 2'b00;
  localparam logic [1:0] CALL_WRITE = 2'b10;
  localparam logic [1:0] CALL_READ  = 2'b01;

  localparam logic [1:0] FAST_WRITE = 2'b00;
  localparam logic [1:0] PD_NORMAL  = 2'b00;

  localparam logic [11:0] DAC_MAX = 12'hFFF;

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'b00,
    MODE_SAW    = 2'b01,
    MODE_TRI    = 2'b10,
    MODE_SQUARE = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALL,
    ST_RELEASE
  } state_t;

  // First fast-write byte: command bits, power-down bits, sample MSBs.
  function automatic logic [7:0] fast_write_hi(input logic [11:0] s);
    return {FAST_WRITE, PD_NORMAL, s[11:8]};
  endfunction

endpackage

// File: rtl/mcp4725_wave_gen.sv
// Waveform sample generator: offers the next sample combinationally and
// commits its accumulator/direction/phase state on a one-cycle strobe.
module mcp4725_wave_gen
  import mcp4725_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        strobe,
  input  logic [1:0]  mode,
  input  logic [11:0] step,
  input  logic [11:0] level,
  output logic [11:0] sample
);

  mode_t       cur_mode;
  mode_t       mode_q;
  logic        mode_changed;
  logic [11:0] acc, acc_eff, acc_next;
  logic        dir_up, dir_eff, dir_next;
  logic        phase_high, phase_eff, phase_next;
  logic [12:0] sum;

  // A mode change restarts the waveform; the restarted state is used
  // directly so a tick in the same cycle as the change already sees it.
  always_comb begin
    cur_mode     = mode_t'(mode);
    mode_changed = (cur_mode != mode_q);
    acc_eff      = mode_changed ? '0   : acc;
    dir_eff      = mode_changed ? 1'b1 : dir_up;
    phase_eff    = mode_changed ? 1'b1 : phase_high;
    sum          = {1'b0, acc_eff} + {1'b0, step};
    acc_next     = acc_eff;
    dir_next     = dir_eff;
    phase_next   = phase_eff;
    sample       = level;
    unique case (cur_mode)
      MODE_HOLD: sample = level;
      MODE_SAW: begin
        acc_next = sum[11:0];
        sample   = acc_next;
      end
      MODE_TRI: begin
        if (dir_eff) begin
          if (sum[12]) begin
            acc_next = DAC_MAX;
            dir_next = 1'b0;
          end else begin
            acc_next = sum[11:0];
          end
        end else if (acc_eff < step) begin
          acc_next = '0;
          dir_next = 1'b1;
        end else begin
          acc_next = acc_eff - step;
        end
        sample = acc_next;
      end
      MODE_SQUARE: begin
        sample     = phase_eff ? level : '0;
        phase_next = ~phase_eff;
      end
      default: sample = level;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= MODE_HOLD;
      acc        <= '0;
      dir_up     <= 1'b1;
      phase_high <= 1'b1;
    end else begin
      mode_q     <= cur_mode;
      acc        <= strobe ? acc_next   : acc_eff;
      dir_up     <= strobe ? dir_next   : dir_eff;
      phase_high <= strobe ? phase_next : phase_eff;
    end
  end

endmodule

// File: rtl/mcp4725_wave_sequencer.sv
// Periodic MCP4725 DAC updater: sample-rate divider plus a call/release
// handshake FSM driving an external IIC core with fast-write frames.
module mcp4725_wave_sequencer
  import mcp4725_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV = 50000
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        iEnable,
  input  logic [1:0]  iMode,
  input  logic [11:0] iStep,
  input  logic [11:0] iLevel,
  input  logic        iClear,
  output logic [1:0]  oCall,
  input  logic        iDone,
  output logic [7:0]  oAddr,
  output logic [7:0]  oData,
  output logic [11:0] oSample,
  output logic        oBusy,
  output logic        oUpdate,
  output logic        oOverrun
);

  localparam int unsigned CW = $clog2(SAMPLE_DIV);
  localparam logic [CW-1:0] DIV_LAST = CW'(SAMPLE_DIV - 1);

  logic [CW-1:0] div_cnt;
  logic          tick;
  logic          strobe;
  logic [11:0]   next_sample;
  state_t        state;

  assign tick   = iEnable && (div_cnt == DIV_LAST);
  assign strobe = tick && (state == ST_IDLE);

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      div_cnt <= '0;
    end else if (!iEnable || div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

  mcp4725_wave_gen u_wave_gen (
    .clk    (CLOCK),
    .rst_n  (RESET),
    .strobe (strobe),
    .mode   (iMode),
    .step   (iStep),
    .level  (iLevel),
    .sample (next_sample)
  );

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state    <= ST_IDLE;
      oCall    <= CALL_IDLE;
      oAddr    <= '0;
      oData    <= '0;
      oSample  <= '0;
      oBusy    <= 1'b0;
      oUpdate  <= 1'b0;
      oOverrun <= 1'b0;
    end else begin
      oUpdate <= 1'b0;
      if (tick && state != ST_IDLE) begin
        oOverrun <= 1'b1;
      end else if (iClear) begin
        oOverrun <= 1'b0;
      end
      unique case (state)
        ST_IDLE: begin
          if (tick) begin
            oAddr <= fast_write_hi(next_sample);
            oData <= next_sample[7:0];
            oCall <= CALL_WRITE;
            oBusy <= 1'b1;
            state <= ST_CALL;
          end
        end
        ST_CALL: begin
          if (iDone) begin
            oCall   <= CALL_IDLE;
            oSample <= {oAddr[3:0], oData};
            oUpdate <= 1'b1;
            state   <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          oBusy <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcp4725_wave_sequencer.sv
// Self-checking bench: IIC core model with programmable iDone delay, a
// write monitor, and a high-level waveform reference model.
module tb_mcp4725_wave_sequencer;

  localparam int DIV = 4;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        iEnable, iClear, iDone;
  logic [1:0]  iMode;
  logic [11:0] iStep, iLevel;
  logic [1:0]  oCall;
  logic [7:0]  oAddr, oData;
  logic [11:0] oSample;
  logic        oBusy, oUpdate, oOverrun;

  mcp4725_wave_sequencer #(.SAMPLE_DIV(DIV)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .iEnable(iEnable), .iMode(iMode),
    .iStep(iStep), .iLevel(iLevel), .iClear(iClear), .oCall(oCall),
    .iDone(iDone), .oAddr(oAddr), .oData(oData), .oSample(oSample),
    .oBusy(oBusy), .oUpdate(oUpdate), .oOverrun(oOverrun)
  );

  always #5 CLOCK = ~CLOCK;

  int tests_run = 0;
  int tests_failed = 0;

  // IIC core model
  int done_delay = 1;
  bit spurious = 1'b0;
  int wait_cnt = 0;
  bit done_sent = 1'b0;
  bit core_done;

  initial begin
    iDone = 1'b0;
    forever begin
      @(negedge CLOCK);
      core_done = 1'b0;
      if (RESET === 1'b1 && oCall == 2'b10 && !done_sent) begin
        wait_cnt++;
        if (wait_cnt >= done_delay) begin
          core_done = 1'b1;
          done_sent = 1'b1;
        end
      end else if (oCall != 2'b10) begin
        wait_cnt  = 0;
        done_sent = 1'b0;
      end
      iDone = core_done | spurious;
    end
  end

  // Write monitor
  logic [11:0] upd_q[$];
  int n_calls = 0, n_upd = 0, unstable = 0, addr_bad = 0, sent_bad = 0, call_bad = 0;
  int cur_len = 0, last_len = 0;
  logic [1:0] prev_call = 2'b00;
  logic [7:0] call_addr = '0, call_data = '0;

  always @(negedge CLOCK) begin
    if (oCall == 2'b01 || oCall == 2'b11) call_bad++;
    if (oCall == 2'b10) begin
      if (prev_call != 2'b10) begin
        n_calls++;
        call_addr = oAddr;
        call_data = oData;
        cur_len = 0;
        if (oAddr[7:4] != 4'h0) addr_bad++;
      end else if (oAddr != call_addr || oData != call_data) begin
        unstable++;
      end
      cur_len++;
    end else if (prev_call == 2'b10) begin
      last_len = cur_len;
    end
    if (oUpdate === 1'b1) begin
      upd_q.push_back(oSample);
      n_upd++;
      if (oSample != {call_addr[3:0], call_data}) sent_bad++;
    end
    prev_call = oCall;
  end

  // Reference model
  int m_mode = 0, m_step = 0, m_level = 0, m_acc = 0;
  bit m_up = 1'b1, m_high = 1'b1;

  task automatic model_reset();
    m_acc = 0; m_up = 1'b1; m_high = 1'b1;
  endtask

  task automatic set_params(input int mode, input int step, input int level);
    if (mode != m_mode) model_reset();
    m_mode = mode; m_step = step; m_level = level;
    iMode = 2'(mode); iStep = 12'(step); iLevel = 12'(level);
  endtask

  task automatic model_step(output logic [11:0] s);
    case (m_mode)
      0: s = 12'(m_level);
      1: begin m_acc = (m_acc + m_step) % 4096; s = 12'(m_acc); end
      2: begin
        if (m_up) begin
          if (m_acc + m_step > 4095) begin m_acc = 4095; m_up = 1'b0; end
          else m_acc = m_acc + m_step;
        end else begin
          if (m_acc < m_step) begin m_acc = 0; m_up = 1'b1; end
          else m_acc = m_acc - m_step;
        end
        s = 12'(m_acc);
      end
      default: begin s = m_high ? 12'(m_level) : 12'h000; m_high = ~m_high; end
    endcase
  endtask

  // Enable until n writes complete, then disable and let any call finish.
  task automatic run_segment(input int n);
    int base, t, budget;
    base = n_upd;
    budget = n * (done_delay + 16) + 40;
    @(negedge CLOCK);
    iEnable = 1'b1;
    t = 0;
    while (n_upd - base < n && t < budget) begin @(negedge CLOCK); t++; end
    if (n_upd - base < n) begin
      tests_run++; tests_failed++;
      $display("FAIL segment_timeout: got %0d writes, required %0d", n_upd - base, n);
    end
    iEnable = 1'b0;
    t = 0;
    while (oBusy === 1'b1 && t < 200) begin @(negedge CLOCK); t++; end
    if (oBusy !== 1'b0) begin
      tests_run++; tests_failed++;
      $display("FAIL idle_timeout: oBusy=%b required 0", oBusy);
    end
    repeat (2) @(negedge CLOCK);
  endtask

  task automatic test_reset();
    RESET = 1'b0; iEnable = 1'b0; iClear = 1'b0;
    iMode = 2'b00; iStep = '0; iLevel = '0;
    repeat (3) @(negedge CLOCK);
    tests_run++; if (oCall !== 2'b00) begin tests_failed++; $display("FAIL reset_oCall: got %b required 00", oCall); end
    tests_run++; if (oAddr !== 8'h00) begin tests_failed++; $display("FAIL reset_oAddr: got %h required 00", oAddr); end
    tests_run++; if (oData !== 8'h00) begin tests_failed++; $display("FAIL reset_oData: got %h required 00", oData); end
    tests_run++; if (oSample !== 12'h000) begin tests_failed++; $display("FAIL reset_oSample: got %h required 000", oSample); end
    tests_run++; if (oBusy !== 1'b0) begin tests_failed++; $display("FAIL reset_oBusy: got %b required 0", oBusy); end
    tests_run++; if (oUpdate !== 1'b0) begin tests_failed++; $display("FAIL reset_oUpdate: got %b required 0", oUpdate); end
    tests_run++; if (oOverrun !== 1'b0) begin tests_failed++; $display("FAIL reset_oOverrun: got %b required 0", oOverrun); end
    RESET = 1'b1;
    model_reset(); m_mode = 0;
    repeat (2) @(negedge CLOCK);
  endtask

  task automatic test_hold();
    int k, bc, bu, t;
    done_delay = 10;
    set_params(0, 0, 12'hABC);
    bc = n_calls; bu = n_upd;
    @(negedge CLOCK);
    iEnable = 1'b1;
    k = 0;
    while (oCall !== 2'b10 && k < 20) begin @(negedge CLOCK); k++; end
    iEnable = 1'b0;
    tests_run++; if (k != DIV) begin tests_failed++; $display("FAIL hold_latency: got %0d cycles required %0d", k, DIV); end
    tests_run++; if (oAddr !== 8'h0A) begin tests_failed++; $display("FAIL hold_oAddr: got %h required 0a", oAddr); end
    tests_run++; if (oData !== 8'hBC) begin tests_failed++; $display("FAIL hold_oData: got %h required bc", oData); end
    tests_run++; if (oBusy !== 1'b1) begin tests_failed++; $display("FAIL hold_busy: got %b required 1", oBusy); end
    t = 0;
    while (oBusy === 1'b1 && t < 100) begin @(negedge CLOCK); t++; end
    repeat (2) @(negedge CLOCK);
    tests_run++; if (last_len != 10) begin tests_failed++; $display("FAIL hold_call_len: got %0d required 10", last_len); end
    tests_run++; if (n_calls - bc != 1) begin tests_failed++; $display("FAIL hold_calls: got %0d required 1", n_calls - bc); end
    tests_run++; if (n_upd - bu != 1) begin tests_failed++; $display("FAIL hold_updates: got %0d required 1", n_upd - bu); end
    tests_run++; if (oSample !== 12'hABC) begin tests_failed++; $display("FAIL hold_oSample: got %h required abc", oSample); end
    tests_run++; if (oBusy !== 1'b0) begin tests_failed++; $display("FAIL hold_idle: got %b required 0", oBusy); end
    tests_run++; if (oOverrun !== 1'b0) begin tests_failed++; $display("FAIL hold_overrun: got %b required 0", oOverrun); end
  endtask

  task automatic test_sawtooth();
    logic [11:0] exp_c[4] = '{12'h800, 12'h000, 12'h800, 12'h000};
    logic [11:0] exp_m, exp, got;
    int base, n;
    done_delay = 1;
    set_params(1, 12'h800, 0);
    base = upd_q.size();
    run_segment(4);
    n = upd_q.size() - base;
    tests_run++; if (n < 4) begin tests_failed++; $display("FAIL saw_count: got %0d required >=4", n); end
    for (int i = 0; i < n; i++) begin
      model_step(exp_m);
      exp = (i < 4) ? exp_c[i] : exp_m;
      got = upd_q[base + i];
      tests_run++; if (got !== exp) begin tests_failed++; $display("FAIL saw_sample[%0d]: got %h required %h", i, got, exp); end
    end
  endtask

  task automatic test_triangle();
    logic [11:0] exp_c[7] = '{12'h600, 12'hC00, 12'hFFF, 12'h9FF, 12'h3FF, 12'h000, 12'h600};
    logic [11:0] exp_m, exp, got;
    int base, n;
    set_params(2, 12'h600, 0);
    base = upd_q.size();
    run_segment(7);
    n = upd_q.size() - base;
    tests_run++; if (n < 7) begin tests_failed++; $display("FAIL tri_count: got %0d required >=7", n); end
    for (int i = 0; i < n; i++) begin
      model_step(exp_m);
      exp = (i < 7) ? exp_c[i] : exp_m;
      got = upd_q[base + i];
      tests_run++; if (got !== exp) begin tests_failed++; $display("FAIL tri_sample[%0d]: got %h required %h", i, got, exp); end
    end
  endtask

  task automatic test_square_switch();
    logic [11:0] exp_c[3] = '{12'h123, 12'h000, 12'h123};
    logic [11:0] exp_m, exp, got;
    int base, n;
    set_params(3, 0, 12'h123);
    base = upd_q.size();
    run_segment(3);
    n = upd_q.size() - base;
    tests_run++; if (n < 3) begin tests_failed++; $display("FAIL sq_count: got %0d required >=3", n); end
    for (int i = 0; i < n; i++) begin
      model_step(exp_m);
      exp = (i < 3) ? exp_c[i] : exp_m;
      got = upd_q[base + i];
      tests_run++; if (got !== exp) begin tests_failed++; $display("FAIL sq_sample[%0d]: got %h required %h", i, got, exp); end
    end
    set_params(1, 1, 12'h123);
    base = upd_q.size();
    run_segment(1);
    n = upd_q.size() - base;
    for (int i = 0; i < n; i++) model_step(exp_m);
    got = (n > 0) ? upd_q[base] : 12'hxxx;
    tests_run++; if (got !== 12'h001) begin tests_failed++; $display("FAIL switch_first: got %h required 001", got); end
  endtask

  task automatic test_spurious_done();
    int bu;
    bu = n_upd;
    @(negedge CLOCK);
    spurious = 1'b1;
    repeat (3) @(negedge CLOCK);
    spurious = 1'b0;
    repeat (2) @(negedge CLOCK);
    tests_run++; if (n_upd != bu) begin tests_failed++; $display("FAIL idle_done_update: got %0d updates required 0", n_upd - bu); end
    tests_run++; if (oCall !== 2'b00) begin tests_failed++; $display("FAIL idle_done_call: got %b required 00", oCall); end
    tests_run++; if (oBusy !== 1'b0) begin tests_failed++; $display("FAIL idle_done_busy: got %b required 0", oBusy); end
  endtask

  task automatic test_random();
    logic [11:0] exp, got;
    int base, n, mode, step, level;
    for (int seg = 0; seg < 8; seg++) begin
      mode  = int'($urandom_range(0, 3));
      step  = (seg == 2) ? 0 : int'($urandom_range(0, 4095));
      level = int'($urandom_range(0, 4095));
      done_delay = int'($urandom_range(1, 2));
      set_params(mode, step, level);
      base = upd_q.size();
      run_segment(int'($urandom_range(3, 8)));
      n = upd_q.size() - base;
      for (int i = 0; i < n; i++) begin
        model_step(exp);
        got = upd_q[base + i];
        tests_run++; if (got !== exp) begin tests_failed++; $display("FAIL rand_seg%0d_mode%0d[%0d]: got %h required %h", seg, mode, i, got, exp); end
      end
    end
    tests_run++; if (oOverrun !== 1'b0) begin tests_failed++; $display("FAIL rand_overrun: got %b required 0", oOverrun); end
    tests_run++; if (unstable != 0) begin tests_failed++; $display("FAIL call_stability: got %0d changes required 0", unstable); end
    tests_run++; if (addr_bad != 0) begin tests_failed++; $display("FAIL addr_upper_bits: got %0d bad required 0", addr_bad); end
    tests_run++; if (sent_bad != 0) begin tests_failed++; $display("FAIL sample_vs_sent: got %0d bad required 0", sent_bad); end
    tests_run++; if (call_bad != 0) begin tests_failed++; $display("FAIL call_encoding: got %0d bad required 0", call_bad); end
  endtask

  task automatic test_overrun();
    int bc, bu, base, n, level;
    logic [11:0] exp;
    done_delay = 20;
    level = int'($urandom_range(0, 4095));
    set_params(0, 0, level);
    tests_run++; if (oOverrun !== 1'b0) begin tests_failed++; $display("FAIL ovr_initial: got %b required 0", oOverrun); end
    bc = n_calls; bu = n_upd; base = upd_q.size();
    run_segment(3);
    n = upd_q.size() - base;
    tests_run++; if (oOverrun !== 1'b1) begin tests_failed++; $display("FAIL ovr_set: got %b required 1", oOverrun); end
    tests_run++; if (n_calls - bc != n_upd - bu) begin tests_failed++; $display("FAIL ovr_extra_call: got %0d calls required %0d", n_calls - bc, n_upd - bu); end
    for (int i = 0; i < n; i++) begin
      model_step(exp);
      tests_run++; if (upd_q[base + i] !== exp) begin tests_failed++; $display("FAIL ovr_sample[%0d]: got %h required %h", i, upd_q[base + i], exp); end
    end
    iClear = 1'b1;
    @(negedge CLOCK);
    iClear = 1'b0;
    @(negedge CLOCK);
    tests_run++; if (oOverrun !== 1'b0) begin tests_failed++; $display("FAIL ovr_clear: got %b required 0", oOverrun); end
  endtask

  task automatic test_reset_mid_call();
    int bu, t, step, base, n, stray;
    logic [11:0] exp, got;
    done_delay = 1;
    step = int'($urandom_range(1, 2047));
    set_params(1, step, 0);
    bu = n_upd;
    @(negedge CLOCK);
    iEnable = 1'b1;
    t = 0;
    while (n_upd - bu < 2 && t < 100) begin @(negedge CLOCK); t++; end
    done_delay = 40;
    t = 0;
    while (oCall === 2'b10 && t < 50) begin @(negedge CLOCK); t++; end
    t = 0;
    while (oCall !== 2'b10 && t < 50) begin @(negedge CLOCK); t++; end
    tests_run++; if (oCall !== 2'b10 || oSample === 12'h000) begin tests_failed++; $display("FAIL rst_setup: oCall=%b oSample=%h required call=10 sample!=0", oCall, oSample); end
    #2 RESET = 1'b0;
    #1;
    tests_run++; if (oCall !== 2'b00) begin tests_failed++; $display("FAIL rst_async_call: got %b required 00", oCall); end
    tests_run++; if (oBusy !== 1'b0) begin tests_failed++; $display("FAIL rst_async_busy: got %b required 0", oBusy); end
    tests_run++; if (oSample !== 12'h000) begin tests_failed++; $display("FAIL rst_async_sample: got %h required 000", oSample); end
    tests_run++; if (oAddr !== 8'h00 || oData !== 8'h00) begin tests_failed++; $display("FAIL rst_async_bytes: got %h%h required 0000", oAddr, oData); end
    iEnable = 1'b0;
    repeat (3) @(negedge CLOCK);
    RESET = 1'b1;
    model_reset();
    done_delay = 1;
    stray = 0;
    repeat (10) begin @(negedge CLOCK); if (oCall == 2'b10) stray++; end
    tests_run++; if (stray != 0) begin tests_failed++; $display("FAIL rst_no_resume: got %0d call cycles required 0", stray); end
    base = upd_q.size();
    run_segment(2);
    n = upd_q.size() - base;
    tests_run++; if (n < 2) begin tests_failed++; $display("FAIL rst_restart_count: got %0d required >=2", n); end
    for (int i = 0; i < n; i++) begin
      model_step(exp);
      got = upd_q[base + i];
      tests_run++; if (got !== exp) begin tests_failed++; $display("FAIL rst_restart[%0d]: got %h required %h", i, got, exp); end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_hold();
    test_sawtooth();
    test_triangle();
    test_square_switch();
    test_spurious_done();
    test_random();
    test_overrun();
    test_reset_mid_call();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
